// File: rtl/lce_req_ctrl_pkg.sv
// Shared types for the LCE request-side control engine.
//   lce_req_type_e  : request/message type encoding (cache side and network side)
//   lce_req_state_e : request FSM states
//   req_needs_metadata : whether a request type waits for LRU way/dirty metadata
package lce_req_ctrl_pkg;

    typedef enum logic [1:0] {
        e_req_rd    = 2'd0,
        e_req_wr    = 2'd1,
        e_req_uc_rd = 2'd2,
        e_req_uc_wr = 2'd3
    } lce_req_type_e;

    typedef enum logic {
        READY = 1'b0,
        SEND  = 1'b1
    } lce_req_state_e;

    // Only cached misses replace a line, so only they need LRU metadata.
    function automatic logic req_needs_metadata(lce_req_type_e t);
        return (t == e_req_rd) || (t == e_req_wr);
    endfunction

endpackage

// File: rtl/lce_sat_counter.sv
// Clear/up saturating counter.
//   clk_i, reset_n_i : clock, async active-low reset
//   clear_i          : force count to 0 next cycle (has priority)
//   up_i             : increment, holding at max_val_p
//   count_o          : current count
module lce_sat_counter #(
    parameter int max_val_p = 4,
    localparam int width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clear_i,
    input  logic                up_i,
    output logic [width_lp-1:0] count_o
);

    logic [width_lp-1:0] count_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count_q <= '0;
        else if (clear_i)
            count_q <= '0;
        else if (up_i && (count_q != width_lp'(max_val_p)))
            count_q <= count_q + 1'b1;
    end

    assign count_o = count_q;

endmodule

// File: rtl/lce_req_ctrl.sv
// LCE request-side control engine.
// Accepts one cache miss / uncached request at a time, waits for LRU metadata
// where needed, issues a single LCE request message, tracks outstanding
// credits and drives cache busy (including a starvation timeout).
//   cache_req_*          : request from the cache, accepted via cache_req_yumi_o
//   cache_req_metadata_* : LRU way/dirty for cached misses
//   cache_req_complete_i, uc_store_complete_i : credit returns
//   mem_pkt_v_i / mem_pkt_yumi_i : command-engine memory port handshakes (timeout)
//   lce_req_*            : outgoing request message, consumed on lce_req_yumi_i
//   credits_full_o / credits_empty_o : outstanding-request count status
module lce_req_ctrl
    import lce_req_ctrl_pkg::*;
#(
    parameter int paddr_width_p       = 40,
    parameter int lce_id_width_p      = 4,
    parameter int assoc_p             = 8,
    parameter int credits_p           = 4,
    parameter int timeout_max_limit_p = 4,
    parameter int non_excl_reads_p    = 0,
    localparam int way_w_lp  = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int cred_w_lp = $clog2(credits_p + 1),
    localparam int tmo_w_lp  = (timeout_max_limit_p > 0) ? $clog2(timeout_max_limit_p + 1) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [lce_id_width_p-1:0] lce_id_i,
    input  logic                      cmd_ready_i,

    input  logic                      cache_req_v_i,
    input  logic [1:0]                cache_req_type_i,
    input  logic [paddr_width_p-1:0]  cache_req_addr_i,
    input  logic [63:0]               cache_req_data_i,
    output logic                      cache_req_yumi_o,
    output logic                      cache_req_busy_o,

    input  logic                      cache_req_metadata_v_i,
    input  logic [way_w_lp-1:0]       cache_req_metadata_way_i,
    input  logic                      cache_req_metadata_dirty_i,

    input  logic                      cache_req_complete_i,
    input  logic                      uc_store_complete_i,

    input  logic [2:0]                mem_pkt_v_i,
    input  logic [2:0]                mem_pkt_yumi_i,

    output logic                      credits_full_o,
    output logic                      credits_empty_o,

    output logic                      lce_req_v_o,
    input  logic                      lce_req_yumi_i,
    output logic [1:0]                lce_req_type_o,
    output logic [paddr_width_p-1:0]  lce_req_addr_o,
    output logic [lce_id_width_p-1:0] lce_req_src_o,
    output logic [way_w_lp-1:0]       lce_req_way_o,
    output logic                      lce_req_dirty_o,
    output logic                      lce_req_non_excl_o,
    output logic [63:0]               lce_req_data_o
);

    lce_req_state_e             state_q;
    lce_req_type_e              type_q;
    logic [paddr_width_p-1:0]   addr_q;
    logic [63:0]                data_q;
    logic [way_w_lp-1:0]        way_q;
    logic                       dirty_q;
    logic                       meta_q;
    logic [cred_w_lp-1:0]       credit_q;
    logic [tmo_w_lp-1:0]        tmo_cnt;

    lce_req_type_e req_type;
    logic          blocked, timeout, credit_send, credit_ret;

    assign req_type = lce_req_type_e'(cache_req_type_i);

    // Any memory packet offered but not taken means the command engine is
    // starved; after enough such cycles we hold the cache off to free ports.
    assign blocked = |(mem_pkt_v_i & ~mem_pkt_yumi_i);

    lce_sat_counter #(.max_val_p(timeout_max_limit_p)) u_timeout (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (~blocked),
        .up_i      (blocked),
        .count_o   (tmo_cnt)
    );

    assign timeout = (tmo_cnt == tmo_w_lp'(timeout_max_limit_p));

    assign credits_full_o   = (credit_q == cred_w_lp'(credits_p));
    assign credits_empty_o  = (credit_q == '0);
    assign cache_req_busy_o = credits_full_o | timeout | ~cmd_ready_i | (state_q != READY);
    assign cache_req_yumi_o = cache_req_v_i & ~cache_req_busy_o;

    assign lce_req_v_o        = (state_q == SEND) & meta_q;
    assign lce_req_type_o     = type_q;
    assign lce_req_addr_o     = addr_q;
    assign lce_req_src_o      = lce_id_i;
    assign lce_req_way_o      = way_q;
    assign lce_req_dirty_o    = dirty_q;
    assign lce_req_non_excl_o = (type_q == e_req_rd) ? 1'(non_excl_reads_p) : 1'b0;
    assign lce_req_data_o     = data_q;

    assign credit_send = lce_req_v_o & lce_req_yumi_i;
    assign credit_ret  = cache_req_complete_i | uc_store_complete_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= READY;
            type_q   <= e_req_rd;
            addr_q   <= '0;
            data_q   <= '0;
            way_q    <= '0;
            dirty_q  <= 1'b0;
            meta_q   <= 1'b0;
            credit_q <= '0;
        end else begin
            if (state_q == READY) begin
                if (cache_req_yumi_o) begin
                    state_q <= SEND;
                    type_q  <= req_type;
                    addr_q  <= cache_req_addr_i;
                    data_q  <= cache_req_data_i;
                    // Uncached requests have no victim, so count as already captured.
                    meta_q  <= ~req_needs_metadata(req_type) | cache_req_metadata_v_i;
                    if (req_needs_metadata(req_type) && cache_req_metadata_v_i) begin
                        way_q   <= cache_req_metadata_way_i;
                        dirty_q <= cache_req_metadata_dirty_i;
                    end
                end
            end else begin
                if (!meta_q && cache_req_metadata_v_i) begin
                    meta_q  <= 1'b1;
                    way_q   <= cache_req_metadata_way_i;
                    dirty_q <= cache_req_metadata_dirty_i;
                end
                if (credit_send) begin
                    state_q <= READY;
                    meta_q  <= 1'b0;
                end
            end

            // Simultaneous send and return cancel out.
            if (credit_send && !credit_ret)
                credit_q <= credit_q + 1'b1;
            else if (credit_ret && !credit_send)
                credit_q <= credit_q - 1'b1;
        end
    end

    a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(credit_ret && !credit_send && (credit_q == '0)));
    a_returns_exclusive: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(cache_req_complete_i && uc_store_complete_i));

endmodule

// File: tb/tb_lce_req_ctrl.sv
module tb_lce_req_ctrl;
    localparam int PA = 40, LID = 4, ASSOC = 8, CRED = 4, TMO = 4, NEX = 0;

    logic            clk = 1'b0, rst_n;
    logic [LID-1:0]  lce_id;
    logic            cmd_ready, req_v, req_yumi, busy;
    logic [1:0]      req_type;
    logic [PA-1:0]   req_addr;
    logic [63:0]     req_data;
    logic            meta_v, meta_dirty;
    logic [2:0]      meta_way;
    logic            complete, uc_complete;
    logic [2:0]      mem_v, mem_yumi;
    logic            full, empty;
    logic            lv, lyumi, ldirty, lnex;
    logic [1:0]      ltype;
    logic [PA-1:0]   laddr;
    logic [LID-1:0]  lsrc;
    logic [2:0]      lway;
    logic [63:0]     ldata;

    always #5 clk = ~clk;

    lce_req_ctrl dut (
        .clk_i(clk), .reset_n_i(rst_n), .lce_id_i(lce_id), .cmd_ready_i(cmd_ready),
        .cache_req_v_i(req_v), .cache_req_type_i(req_type), .cache_req_addr_i(req_addr),
        .cache_req_data_i(req_data), .cache_req_yumi_o(req_yumi), .cache_req_busy_o(busy),
        .cache_req_metadata_v_i(meta_v), .cache_req_metadata_way_i(meta_way),
        .cache_req_metadata_dirty_i(meta_dirty),
        .cache_req_complete_i(complete), .uc_store_complete_i(uc_complete),
        .mem_pkt_v_i(mem_v), .mem_pkt_yumi_i(mem_yumi),
        .credits_full_o(full), .credits_empty_o(empty),
        .lce_req_v_o(lv), .lce_req_yumi_i(lyumi), .lce_req_type_o(ltype),
        .lce_req_addr_o(laddr), .lce_req_src_o(lsrc), .lce_req_way_o(lway),
        .lce_req_dirty_o(ldirty), .lce_req_non_excl_o(lnex), .lce_req_data_o(ldata)
    );

    int errors = 0, checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One pending transaction at most; credits and blocked-cycle history as ints.
    bit            m_pend, m_meta, m_dirty;
    int            m_type, m_way, m_cred, m_blk;
    logic [PA-1:0] m_addr;
    logic [63:0]   m_data;
    bit            mv_yumi, mv_send, mv_ret;

    function automatic bit m_busy();
        return (m_cred == CRED) || (m_blk >= TMO) || !cmd_ready || m_pend;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_meta = 0; m_dirty = 0; m_type = 0; m_way = 0;
            m_cred = 0; m_blk = 0; m_addr = '0; m_data = '0;
        end else begin
            mv_yumi = req_v && !m_busy();
            mv_send = m_pend && m_meta && lyumi;
            mv_ret  = complete || uc_complete;
            m_cred  = m_cred + int'(mv_send) - int'(mv_ret);
            m_blk   = ((mem_v & ~mem_yumi) != 0) ? ((m_blk < TMO) ? m_blk + 1 : TMO) : 0;
            if (mv_yumi) begin
                m_pend = 1; m_type = int'(req_type); m_addr = req_addr; m_data = req_data;
                m_meta = (m_type >= 2) || meta_v;
                if (m_type < 2 && meta_v) begin m_way = int'(meta_way); m_dirty = meta_dirty; end
            end else if (m_pend) begin
                if (!m_meta && meta_v) begin m_meta = 1; m_way = int'(meta_way); m_dirty = meta_dirty; end
                if (mv_send) begin m_pend = 0; m_meta = 0; end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_lv", lv, 0);
            chk("rst_yumi", req_yumi, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
        end else begin
            chk("busy", busy, m_busy());
            chk("yumi", req_yumi, req_v && !m_busy());
            chk("full", full, m_cred == CRED);
            chk("empty", empty, m_cred == 0);
            chk("lv", lv, m_pend && m_meta);
            if (m_pend && m_meta) begin
                chk("ltype", ltype, m_type);
                chk("laddr", laddr, m_addr);
                chk("lsrc", lsrc, lce_id);
                chk("lnex", lnex, (m_type == 0) ? NEX : 0);
                if (m_type < 2) begin
                    chk("lway", lway, m_way);
                    chk("ldirty", ldirty, m_dirty);
                end
                if (m_type == 3) chk("ldata", ldata, m_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_uc(input logic [PA-1:0] a, input bit with_ret);
        req_v = 1; req_type = 2'd2; req_addr = a;
        tick(); req_v = 0;
        lyumi = 1; complete = with_ret;
        tick(); lyumi = 0; complete = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; lce_id = 4'h5; cmd_ready = 1; req_v = 0; req_type = 0; req_addr = '0;
        req_data = '0; meta_v = 0; meta_way = 0; meta_dirty = 0; complete = 0;
        uc_complete = 0; mem_v = 0; mem_yumi = 0; lyumi = 0;
        tick(); tick();
        chk("lit_rst_empty", empty, 1);
        chk("lit_rst_lv", lv, 0);
        rst_n = 1; tick();

        // Load miss, metadata two cycles after yumi
        req_v = 1; req_type = 2'd0; req_addr = 40'h80000040;
        #1 chk("lit_t1_yumi", req_yumi, 1);
        tick(); req_v = 0;
        tick(); chk("lit_t1_v_early", lv, 0);
        meta_v = 1; meta_way = 3; meta_dirty = 1;
        tick(); meta_v = 0;
        #1 chk("lit_t1_v", lv, 1);
        chk("lit_t1_type", ltype, 0);
        chk("lit_t1_way", lway, 3);
        chk("lit_t1_dirty", ldirty, 1);
        lyumi = 1; tick(); lyumi = 0;
        #1 chk("lit_t1_empty", empty, 0);
        complete = 1; tick(); complete = 0;
        #1 chk("lit_t1_ret", empty, 1);

        // Uncached store
        req_v = 1; req_type = 2'd3; req_addr = 40'h1000; req_data = 64'hDEADBEEF;
        tick(); req_v = 0;
        #1 chk("lit_t2_v", lv, 1);
        chk("lit_t2_type", ltype, 3);
        chk("lit_t2_data", ldata, 64'hDEADBEEF);
        lyumi = 1; tick(); lyumi = 0;
        #1 chk("lit_t2_empty", empty, 0);
        uc_complete = 1; tick(); uc_complete = 0;
        #1 chk("lit_t2_ret", empty, 1);

        // Fill all credits
        for (int i = 0; i < 4; i++) begin
            req_v = 1; req_type = 2'd1; req_addr = 40'h2000 + 40'(i * 64);
            meta_v = 1; meta_way = 3'(i); meta_dirty = 1'(i & 1);
            tick(); req_v = 0; meta_v = 0;
            lyumi = 1; tick(); lyumi = 0;
        end
        #1 chk("lit_t3_full", full, 1);
        chk("lit_t3_busy", busy, 1);
        req_v = 1; req_type = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lit_t3_noyumi", req_yumi, 0);
            tick();
        end
        req_v = 0;
        complete = 1; tick(); complete = 0;
        #1 chk("lit_t3_busy_drop", busy, 0);
        chk("lit_t3_notfull", full, 0);
        for (int i = 0; i < 3; i++) begin complete = 1; tick(); complete = 0; end
        #1 chk("lit_t3_drained", empty, 1);

        // Timeout
        mem_v = 3'b001; mem_yumi = 3'b000;
        for (int c = 0; c < 4; c++) begin
            #1 chk("lit_t4_not_busy", busy, 0);
            tick();
        end
        #1 chk("lit_t4_busy", busy, 1);
        mem_yumi = 3'b001;
        tick();
        #1 chk("lit_t4_clear", busy, 0);
        mem_v = 0; mem_yumi = 0;

        // cmd_ready low, then simultaneous send + return at count 2
        cmd_ready = 0; req_v = 1; req_type = 2'd2; req_addr = 40'h3000;
        #1 chk("lit_t5_busy", busy, 1);
        chk("lit_t5_noyumi", req_yumi, 0);
        tick();
        #1 chk("lit_t5_noyumi2", req_yumi, 0);
        req_v = 0; cmd_ready = 1;
        send_uc(40'h3000, 0);
        send_uc(40'h3040, 0);
        send_uc(40'h3080, 1);
        complete = 1; tick(); complete = 0;
        #1 chk("lit_t5_cnt1", empty, 0);
        complete = 1; tick(); complete = 0;
        #1 chk("lit_t5_cnt0", empty, 1);

        // Reset while a message is stalled on the network
        req_v = 1; req_type = 2'd0; req_addr = 40'h4000; meta_v = 1; meta_way = 5; meta_dirty = 0;
        tick(); req_v = 0; meta_v = 0;
        tick();
        #1 chk("lit_t6_v", lv, 1);
        rst_n = 0;
        #1 chk("lit_t6_v_drop", lv, 0);
        chk("lit_t6_empty", empty, 1);
        chk("lit_t6_busy", busy, 0);
        tick(); rst_n = 1; tick();
        send_uc(40'h5000, 0);
        #1 chk("lit_t6_after", empty, 0);
        complete = 1; tick(); complete = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
